// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential reads ahead of the CPU, buffered with their PCs, flushed on redirect.
// Optional fetch/flush counters are enabled by defining PREFETCH_STATS_EN.
module instr_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
`ifdef PREFETCH_STATS_EN
    output logic [15:0]       stat_fetches,
    output logic [15:0]       stat_flushes,
`endif
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t             fifo_q [DEPTH];
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               inflight_q, inflight_d;
    logic               issue, push, pop;
    entry_t             push_entry;

    // Credit check: buffered entries plus the outstanding read must leave room.
    assign issue = !rst && !redirect_valid &&
                   ((SUM_W'(count_q) + SUM_W'(inflight_q)) < SUM_W'(DEPTH));
    assign push  = inflight_q && !redirect_valid;
    assign pop   = instr_valid && instr_ready && !redirect_valid;

    assign mem_req     = issue;
    assign mem_addr    = fetch_pc_q;
    assign instr_valid = (count_q != '0);
    assign instr_data  = fifo_q[rd_ptr_q].data;
    assign instr_pc    = fifo_q[rd_ptr_q].pc;
    assign push_entry  = '{data: mem_data, pc: req_pc_q};

    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        if (redirect_valid) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = redirect_addr;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                req_pc_d   = fetch_pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            if (push) fifo_q[wr_ptr_q] <= push_entry;
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [15:0] stat_fetches_q, stat_fetches_d;
    logic [15:0] stat_flushes_q, stat_flushes_d;

    // Saturating event counters.
    always_comb begin
        stat_fetches_d = stat_fetches_q;
        stat_flushes_d = stat_flushes_q;
        if (mem_req && stat_fetches_q != 16'hFFFF)        stat_fetches_d = stat_fetches_q + 16'd1;
        if (redirect_valid && stat_flushes_q != 16'hFFFF) stat_flushes_d = stat_flushes_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_fetches_q <= '0;
            stat_flushes_q <= '0;
        end else begin
            stat_fetches_q <= stat_fetches_d;
            stat_flushes_q <= stat_flushes_d;
        end
    end

    assign stat_fetches = stat_fetches_q;
    assign stat_flushes = stat_flushes_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench for instr_prefetch_queue: directed scenarios push expected PCs, a monitor checks each consumed instruction.
module tb_instr_prefetch_queue;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
`ifdef PREFETCH_STATS_EN
    logic [15:0]   stat_fetches;
    logic [15:0]   stat_flushes;
`endif

    int checks   = 0;
    int failures = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] cap_addr = '0;
    logic [AW-1:0] mon_pc;

    instr_prefetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
`ifdef PREFETCH_STATS_EN
        .stat_fetches   (stat_fetches),
        .stat_flushes   (stat_flushes),
`endif
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    // Memory model: word at address A is A + 0x1000, returned the cycle after the request.
    always @(negedge clk) cap_addr <= mem_addr;
    always @(posedge clk) begin
        #1;
        mem_data = {4'b0000, cap_addr} + 16'h1000;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted instruction must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: got pc 0x%0h expected no instruction", instr_pc);
            end else begin
                mon_pc = exp_q.pop_front();
                chk("pop_pc", 32'(instr_pc), 32'(mon_pc));
                chk("pop_data", 32'(instr_data), 32'({4'b0000, mon_pc} + 16'h1000));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_and_release(input logic rdy, input logic redir, input logic [AW-1:0] raddr);
        rst = 1'b1;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        step();
        step();
        instr_ready = rdy;
        redirect_valid = redir;
        redirect_addr = raddr;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h000);
        chk("rst_valid", 32'(instr_valid), 32'd0);
`ifdef PREFETCH_STATS_EN
        chk("rst_stat_fetches", 32'(stat_fetches), 32'd0);
        chk("rst_stat_flushes", 32'(stat_flushes), 32'd0);
`endif

        // Startup stream with instr_ready held high.
        for (int k = 0; k < 8; k++) exp_q.push_back(AW'(k));
        reset_and_release(1'b1, 1'b0, '0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("t1_req0", 32'(mem_req), 32'd1);
                chk("t1_addr0", 32'(mem_addr), 32'h000);
                chk("t1_valid0", 32'(instr_valid), 32'd0);
            end
            if (i == 1) begin
                chk("t1_valid1", 32'(instr_valid), 32'd0);
                chk("t1_addr1", 32'(mem_addr), 32'h001);
            end
            if (i == 2) chk("t1_valid2", 32'(instr_valid), 32'd1);
            step();
        end
        instr_ready = 1'b0;
        chk("t1_drained", 32'(exp_q.size()), 32'd0);

        // Back-pressure: exactly DEPTH reads, then resume at 0x004.
        for (int k = 0; k < 10; k++) exp_q.push_back(AW'(k));
        reset_and_release(1'b0, 1'b0, '0);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i < 9) chk("t2_req", 32'(mem_req), 32'(i < 4));
            if (i < 4) chk("t2_addr", 32'(mem_addr), 32'(i));
            if (i == 6) begin
                chk("t2_full_valid", 32'(instr_valid), 32'd1);
                chk("t2_full_head", 32'(instr_pc), 32'h000);
            end
            if (i == 9) begin
                chk("t2_resume_req", 32'(mem_req), 32'd1);
                chk("t2_resume_addr", 32'(mem_addr), 32'h004);
            end
            step();
            if (i == 7) instr_ready = 1'b1;
        end
        instr_ready = 1'b0;
        chk("t2_drained", 32'(exp_q.size()), 32'd0);

        // Redirect with 3 buffered entries and one read in flight.
        for (int k = 0; k < 4; k++) exp_q.push_back(AW'(12'h1A0 + k));
        reset_and_release(1'b0, 1'b0, '0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i == 4) begin
                chk("t3_pre_valid", 32'(instr_valid), 32'd1);
                chk("t3_redir_noreq", 32'(mem_req), 32'd0);
            end
            if (i == 5) begin
                chk("t3_r1_valid", 32'(instr_valid), 32'd0);
                chk("t3_r1_req", 32'(mem_req), 32'd1);
                chk("t3_r1_addr", 32'(mem_addr), 32'h1A0);
            end
            if (i == 6) chk("t3_r2_valid", 32'(instr_valid), 32'd0);
            if (i == 7) begin
                chk("t3_r3_valid", 32'(instr_valid), 32'd1);
                chk("t3_r3_pc", 32'(instr_pc), 32'h1A0);
            end
            step();
            if (i == 3) begin
                redirect_valid = 1'b1;
                redirect_addr = 12'h1A0;
            end
            if (i == 4) redirect_valid = 1'b0;
            if (i == 6) instr_ready = 1'b1;
        end
        instr_ready = 1'b0;
        chk("t3_drained", 32'(exp_q.size()), 32'd0);

        // Redirect coinciding with a pop: the pop is dropped.
        exp_q.push_back(12'h000);
        exp_q.push_back(12'h001);
        exp_q.push_back(12'h002);
        for (int k = 0; k < 4; k++) exp_q.push_back(AW'(12'h040 + k));
        reset_and_release(1'b1, 1'b0, '0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 5) chk("t4_pop_during_redir", 32'(instr_valid), 32'd1);
            if (i == 6) chk("t4_r1_valid", 32'(instr_valid), 32'd0);
            if (i == 7) chk("t4_r2_valid", 32'(instr_valid), 32'd0);
            if (i == 8) chk("t4_r3_pc", 32'(instr_pc), 32'h040);
            step();
            if (i == 4) begin
                redirect_valid = 1'b1;
                redirect_addr = 12'h040;
            end
            if (i == 5) redirect_valid = 1'b0;
        end
        instr_ready = 1'b0;
        chk("t4_drained", 32'(exp_q.size()), 32'd0);

        // Address wrap from 0xFFE.
        exp_q.push_back(12'hFFE);
        exp_q.push_back(12'hFFF);
        exp_q.push_back(12'h000);
        exp_q.push_back(12'h001);
        reset_and_release(1'b1, 1'b1, 12'hFFE);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 1) chk("t5_addr", 32'(mem_addr), 32'hFFE);
            if (i == 3) begin
                chk("t5_valid", 32'(instr_valid), 32'd1);
                chk("t5_wrap_addr", 32'(mem_addr), 32'h000);
            end
            step();
            if (i == 0) redirect_valid = 1'b0;
        end
        instr_ready = 1'b0;
        chk("t5_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a cycle.
        for (int k = 0; k < 4; k++) exp_q.push_back(AW'(k));
        reset_and_release(1'b1, 1'b0, '0);
        for (int i = 0; i < 6; i++) step();
        #2 rst = 1'b1;
        #1;
        chk("t6_mem_addr", 32'(mem_addr), 32'h000);
        chk("t6_mem_req", 32'(mem_req), 32'd0);
        chk("t6_valid", 32'(instr_valid), 32'd0);
`ifdef PREFETCH_STATS_EN
        chk("t6_stat_fetches", 32'(stat_fetches), 32'd0);
        chk("t6_stat_flushes", 32'(stat_flushes), 32'd0);
`endif
        chk("t6_drained", 32'(exp_q.size()), 32'd0);

`ifdef PREFETCH_STATS_EN
        // Two redirects counted by the flush counter.
        reset_and_release(1'b0, 1'b0, '0);
        step();
        redirect_valid = 1'b1;
        redirect_addr = 12'h100;
        step();
        redirect_valid = 1'b0;
        step();
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        step();
        chk("t7_stat_flushes", 32'(stat_flushes), 32'd2);
        rst = 1'b1;
        #1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
